// File: rtl/tx_fir_sym.sv
// Symmetric odd-length FIR: delay line -> pre-add/multiply -> sum/shift, with shadow/active coefficient banks.
// Define TX_FIR_SAT_EN to saturate the output; otherwise the shifted sum wraps to DATA_W bits.
module tx_fir_sym #(
   parameter  int DATA_W = 18,
   parameter  int COEF_W = 18,
   parameter  int N_TAPS = 21,
   localparam int NH     = (N_TAPS + 1) / 2,
   localparam int AW     = $clog2(NH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] x_in,
   input  logic              in_valid,
   input  logic              coef_we,
   input  logic [AW-1:0]     coef_addr,
   input  logic [COEF_W-1:0] coef_wdata,
   input  logic              coef_commit,
   output logic [DATA_W-1:0] y,
   output logic              out_valid
);

   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int ACC_W  = PROD_W + $clog2(NH) + 1;
   localparam logic [AW:0] NH_V = (AW + 1)'(NH);
   localparam logic signed [COEF_W-1:0] IMPULSE = {1'b0, {(COEF_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [DATA_W-1:0] taps     [N_TAPS];
   logic signed [COEF_W-1:0] coef_sh  [NH];
   logic signed [COEF_W-1:0] coef_act [NH];
   logic signed [DATA_W:0]   pre      [NH];
   logic signed [PROD_W-1:0] prod     [NH];
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_sh;
   logic [DATA_W-1:0]        y_next;
   logic                     v_taps;
   logic                     v_prod;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_TAPS; i++) taps[i] <= '0;
         v_taps <= 1'b0;
      end else begin
         v_taps <= in_valid;
         if (in_valid) begin
            taps[0] <= x_in;
            for (int i = 1; i < N_TAPS; i++) taps[i] <= taps[i-1];
         end
      end
   end

   // NOTE: both coefficient banks are registers, not RAM, so they take a reset value like any other state.
   // Commit copies the pre-write shadow because non-blocking reads see the old contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NH; i++) begin
            coef_sh[i]  <= (i == NH - 1) ? IMPULSE : '0;
            coef_act[i] <= (i == NH - 1) ? IMPULSE : '0;
         end
      end else begin
         if (coef_commit) begin
            for (int i = 0; i < NH; i++) coef_act[i] <= coef_sh[i];
         end
         if (coef_we && ({1'b0, coef_addr} < NH_V)) coef_sh[coef_addr] <= coef_wdata;
      end
   end

   // NOTE: every combinational output is assigned on every path, so no latches are inferred.
   always_comb begin
      for (int i = 0; i < NH - 1; i++) begin
         pre[i] = (DATA_W + 1)'(taps[i]) + (DATA_W + 1)'(taps[N_TAPS-1-i]);
      end
      pre[NH-1] = (DATA_W + 1)'(taps[NH-1]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NH; i++) prod[i] <= '0;
         v_prod <= 1'b0;
      end else begin
         for (int i = 0; i < NH; i++) prod[i] <= PROD_W'(pre[i]) * PROD_W'(coef_act[i]);
         v_prod <= v_taps;
      end
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < NH; i++) acc = acc + ACC_W'(prod[i]);
      acc_sh = acc >>> (COEF_W - 1);
   end

`ifdef TX_FIR_SAT_EN
   always_comb begin
      y_next = acc_sh[DATA_W-1:0];
      if (acc_sh > SAT_MAX)      y_next = SAT_MAX[DATA_W-1:0];
      else if (acc_sh < SAT_MIN) y_next = SAT_MIN[DATA_W-1:0];
   end
`else
   logic unused_hi;
   assign unused_hi = ^{acc_sh[ACC_W-1:DATA_W], SAT_MAX, SAT_MIN};
   assign y_next    = acc_sh[DATA_W-1:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= v_prod;
         if (v_prod) y <= y_next;
      end
   end

endmodule

// File: tb/tb_tx_fir_sym.sv
// Scoreboard bench for tx_fir_sym: a convolution model of the symmetric filter predicts each output,
// a negedge monitor compares samples, latency and hold behaviour.
module tb_tx_fir_sym;

   localparam int DATA_W = 18;
   localparam int COEF_W = 18;
   localparam int N_TAPS = 21;
   localparam int NH     = (N_TAPS + 1) / 2;
   localparam int AW     = $clog2(NH);
   localparam longint Y_MAX = (longint'(1) << (DATA_W - 1)) - 1;
   localparam longint Y_MIN = -(longint'(1) << (DATA_W - 1));
   localparam longint IMP   = (longint'(1) << (COEF_W - 1)) - 1;
`ifdef TX_FIR_SAT_EN
   localparam longint ALL_MAX_Y = 131071;
`else
   localparam longint ALL_MAX_Y = 131030;
`endif

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] x_in;
   logic              in_valid;
   logic              coef_we;
   logic [AW-1:0]     coef_addr;
   logic [COEF_W-1:0] coef_wdata;
   logic              coef_commit;
   logic [DATA_W-1:0] y;
   logic              out_valid;

   tx_fir_sym dut (
      .clk        (clk),
      .reset      (reset),
      .x_in       (x_in),
      .in_valid   (in_valid),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .coef_commit(coef_commit),
      .y          (y),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int phase = 0;
   int pulses[3] = '{0, 0, 0};
   logic [DATA_W-1:0] exp_q[$];
   time               lat_q[$];
   longint            hist[$];
   longint            act[NH];
   longint            sh[NH];
   logic [DATA_W-1:0] last_y = '0;

   task automatic check(input string name, input longint got, input longint want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   // Direct convolution with the full mirrored impulse response, then floor-divide and limit.
   function automatic logic [DATA_W-1:0] model_y();
      longint s = 0;
      longint xk;
      int     ci;
      for (int k = 0; k < N_TAPS; k++) begin
         xk = (k < hist.size()) ? hist[k] : 0;
         ci = (k < N_TAPS - 1 - k) ? k : N_TAPS - 1 - k;
         s += act[ci] * xk;
      end
      s = s >>> (COEF_W - 1);
`ifdef TX_FIR_SAT_EN
      if (s > Y_MAX) s = Y_MAX;
      else if (s < Y_MIN) s = Y_MIN;
`endif
      return s[DATA_W-1:0];
   endfunction

   task automatic model_reset();
      hist.delete();
      exp_q.delete();
      lat_q.delete();
      for (int i = 0; i < NH; i++) begin
         act[i] = (i == NH - 1) ? IMP : 0;
         sh[i]  = (i == NH - 1) ? IMP : 0;
      end
   endtask

   task automatic step(input bit v, input logic [DATA_W-1:0] x, input bit we = 0,
                       input int addr = 0, input logic [COEF_W-1:0] wd = '0, input bit cm = 0);
      @(negedge clk);
      in_valid    = v;
      x_in        = x;
      coef_we     = we;
      coef_addr   = addr[AW-1:0];
      coef_wdata  = wd;
      coef_commit = cm;
      if (v) begin
         hist.push_front(longint'($signed(x)));
         if (hist.size() > N_TAPS) void'(hist.pop_back());
      end
      if (cm) for (int i = 0; i < NH; i++) act[i] = sh[i];
      if (we && addr < NH) sh[addr] = longint'($signed(wd));
      if (v) begin
         exp_q.push_back(model_y());
         lat_q.push_back($time);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         last_y = '0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_valid_unexpected: got y=%0d with no sample pending at %0t", y, $time);
         end else begin
            logic [DATA_W-1:0] e;
            time               t;
            e = exp_q.pop_front();
            t = lat_q.pop_front();
            check("y_sample", longint'(y), longint'(e));
            check("latency", longint'($time - t), 30);
            last_y = e;
            pulses[phase]++;
            if ((phase == 1 || phase == 2) && pulses[phase] == 11)
               check("impulse_peak", longint'(y), 131070);
         end
      end else begin
         check("y_hold", longint'(y), longint'(last_y));
      end
   end

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      x_in        = '0;
      coef_we     = 1'b0;
      coef_addr   = '0;
      coef_wdata  = '0;
      coef_commit = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_y", longint'(y), 0);
      check("reset_out_valid", longint'(out_valid), 0);
      #2 reset = 1'b0;

      // Impulse through the reset coefficient set.
      phase = 1;
      step(1, DATA_W'(131071));
      repeat (25) step(1, '0);
      repeat (4) step(0, '0);
      phase = 0;

      // Shadow write stays invisible until commit.
      step(0, '0, 1, 10, COEF_W'(65536));
      repeat (25) step(1, DATA_W'(1000));
      repeat (4) step(0, '0);
      check("shadow_not_active", longint'(y), 999);
      step(1, DATA_W'(1000), 0, 0, '0, 1);
      repeat (25) step(1, DATA_W'(1000));
      repeat (4) step(0, '0);
      check("after_commit", longint'(y), 500);

      // Gapped input: 1,0,0,1.
      step(1, DATA_W'(500));
      step(0, '0);
      step(0, '0);
      step(1, DATA_W'(-300));
      repeat (5) step(0, '0);

      // Random traffic with occasional writes (some out of range) and commits, sometimes together.
      repeat (250) begin
         int r;
         r = $urandom_range(0, 9);
         step($urandom_range(0, 3) != 0, DATA_W'($urandom), r <= 1, $urandom_range(0, 15),
              COEF_W'($urandom), r == 1 || r == 2);
      end

      // Reset between edges while outputs are live.
      repeat (6) step(1, DATA_W'($urandom));
      #2;
      check("pre_reset_out_valid", longint'(out_valid), 1);
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("mid_reset_y", longint'(y), 0);
      check("mid_reset_out_valid", longint'(out_valid), 0);
      model_reset();
      @(negedge clk);
      #2 reset = 1'b0;

      // Out-of-range write then commit leaves the impulse set in place.
      phase = 2;
      step(0, '0, 1, 15, COEF_W'(12345));
      step(0, '0, 0, 0, '0, 1);
      step(1, DATA_W'(131071));
      repeat (25) step(1, '0);
      repeat (4) step(0, '0);
      phase = 0;

      // Full-scale coefficients and input: saturate or wrap.
      for (int i = 0; i < NH; i++) step(0, '0, 1, i, COEF_W'(131071));
      step(0, '0, 0, 0, '0, 1);
      repeat (30) step(1, DATA_W'(131071));
      repeat (5) step(0, '0);
      check("full_scale", longint'(y), ALL_MAX_Y);

      check("scoreboard_drained", longint'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
